// File: rtl/rvv_backend_uop_sequencer.sv
// rvv_backend_uop_sequencer: maps command-queue head instructions onto uop-queue push lanes
// and carries the uop index of slot 0 across cycles for multi-cycle expansions.
module rvv_backend_uop_sequencer #(
  parameter int NUM_DE_INST     = 2,
  parameter int NUM_DE_UOP      = 4,
  parameter int UOP_INDEX_WIDTH = 3
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NUM_DE_INST-1:0]                     inst_valid,
  input  logic [NUM_DE_INST*UOP_INDEX_WIDTH-1:0]     inst_uop_num,
  input  logic [2:0]                                 uq_free_cnt,
  output logic [NUM_DE_INST-1:0]                     pop,
  output logic [NUM_DE_UOP-1:0]                      push,
  output logic [NUM_DE_UOP*$clog2(NUM_DE_INST)-1:0]  lane_inst_sel,
  output logic [NUM_DE_UOP*UOP_INDEX_WIDTH-1:0]      lane_uop_index,
  output logic [NUM_DE_UOP-1:0]                      lane_last,
  output logic [UOP_INDEX_WIDTH-1:0]                 uop_index_remain
);
  localparam int UW = UOP_INDEX_WIDTH;
  localparam int SW = $clog2(NUM_DE_INST);
  localparam int CW = UW + $clog2(NUM_DE_UOP) + 2;
  logic [UW-1:0]          uop_index_remain_q, uop_index_remain_d;
  logic [NUM_DE_INST-1:0] ev;
  logic [CW-1:0]          cap, used, need, take;
  logic [UW-1:0]          start, ix;
  logic                   blocked, illegal;
  always_comb begin
    cap = (uq_free_cnt > 3'(NUM_DE_UOP)) ? CW'(NUM_DE_UOP) : CW'(uq_free_cnt);
    illegal = uop_index_remain_q > inst_uop_num[UW-1:0];
    ev[0] = inst_valid[0];
    for (int i = 1; i < NUM_DE_INST; i++) ev[i] = inst_valid[i] & ev[i-1];
    push = '0;
    pop = '0;
    lane_inst_sel = '0;
    lane_uop_index = '0;
    lane_last = '0;
    used = '0;
    need = '0;
    take = '0;
    start = '0;
    ix = '0;
    blocked = illegal;
    uop_index_remain_d = (!ev[0] || illegal) ? uop_index_remain_q : '0;
    for (int i = 0; i < NUM_DE_INST; i++) begin
      start = (i == 0) ? uop_index_remain_q : '0;
      need = CW'(inst_uop_num[i*UW+:UW]) + CW'(1) - CW'(start);
      take = (need > cap - used) ? cap - used : need;
      if (ev[i] && !blocked) begin
        for (int j = 0; j < NUM_DE_UOP; j++) begin
          if (CW'(j) >= used && CW'(j) < used + take) begin
            ix = start + UW'(CW'(j) - used);
            push[j] = 1'b1;
            lane_inst_sel[j*SW+:SW] = SW'(i);
            lane_uop_index[j*UW+:UW] = ix;
            lane_last[j] = ix == inst_uop_num[i*UW+:UW];
          end
        end
        if (take == need) pop[i] = 1'b1;
        else begin
          // a partially issued slot becomes (or stays) the head next cycle
          blocked = 1'b1;
          uop_index_remain_d = (i == 0) ? uop_index_remain_q + UW'(take) : UW'(take);
        end
        used = used + take;
      end else blocked = 1'b1;
    end
    if (!rst_n) begin
      push = '0;
      pop = '0;
      lane_inst_sel = '0;
      lane_uop_index = '0;
      lane_last = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) uop_index_remain_q <= '0;
    else uop_index_remain_q <= uop_index_remain_d;
  assign uop_index_remain = uop_index_remain_q;
  a_remain_legal: assert property (@(posedge clk) disable iff (!rst_n) !(ev[0] && illegal));
  a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (uop_index_remain_d != '0 && !pop[0]) |=> $stable(inst_uop_num[UW-1:0]));
endmodule

// File: tb/tb_rvv_backend_uop_sequencer.sv
// tb_rvv_backend_uop_sequencer: directed checks of lane allocation, pop and uop-index carry.
module tb_rvv_backend_uop_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  inst_valid;
  logic [5:0]  inst_uop_num;
  logic [2:0]  uq_free_cnt;
  logic [1:0]  pop;
  logic [3:0]  push;
  logic [3:0]  lane_inst_sel;
  logic [11:0] lane_uop_index;
  logic [3:0]  lane_last;
  logic [2:0]  uop_index_remain;
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  rvv_backend_uop_sequencer dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_uop_num(inst_uop_num),
    .uq_free_cnt(uq_free_cnt), .pop(pop), .push(push), .lane_inst_sel(lane_inst_sel),
    .lane_uop_index(lane_uop_index), .lane_last(lane_last), .uop_index_remain(uop_index_remain)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [1:0] v, input logic [2:0] n0, input logic [2:0] n1, input logic [2:0] f);
    inst_valid = v;
    inst_uop_num = {n1, n0};
    uq_free_cnt = f;
    #1;
  endtask
  task automatic lanes(input string tag, input logic [3:0] p, input logic [3:0] s,
                       input logic [11:0] ix, input logic [3:0] l, input logic [1:0] pp);
    chk({tag, ".push"}, 32'(push), 32'(p));
    chk({tag, ".sel"}, 32'(lane_inst_sel), 32'(s));
    chk({tag, ".idx"}, 32'(lane_uop_index), 32'(ix));
    chk({tag, ".last"}, 32'(lane_last), 32'(l));
    chk({tag, ".pop"}, 32'(pop), 32'(pp));
  endtask
  task automatic tick(input string tag, input logic [2:0] exp_remain);
    @(posedge clk);
    #1;
    chk({tag, ".remain"}, 32'(uop_index_remain), 32'(exp_remain));
  endtask
  initial begin
    rst_n = 1'b0;
    drive(2'b11, 3'd0, 3'd1, 3'd4);
    repeat (2) @(posedge clk);
    #1;
    lanes("rst", 4'b0000, 4'b0000, 12'h000, 4'b0000, 2'b00);
    chk("rst.remain", 32'(uop_index_remain), 32'd0);
    rst_n = 1'b1;
    #1;
    lanes("t2", 4'b0111, 4'b0110, {3'd0, 3'd1, 3'd0, 3'd0}, 4'b0101, 2'b11);
    tick("t2", 3'd0);
    drive(2'b01, 3'd7, 3'd0, 3'd4);
    lanes("t3a", 4'b1111, 4'b0000, {3'd3, 3'd2, 3'd1, 3'd0}, 4'b0000, 2'b00);
    tick("t3a", 3'd4);
    drive(2'b01, 3'd7, 3'd0, 3'd7);
    lanes("t3b", 4'b1111, 4'b0000, {3'd7, 3'd6, 3'd5, 3'd4}, 4'b1000, 2'b01);
    tick("t3b", 3'd0);
    drive(2'b11, 3'd2, 3'd3, 3'd4);
    lanes("t4a", 4'b1111, 4'b1000, {3'd0, 3'd2, 3'd1, 3'd0}, 4'b0100, 2'b01);
    tick("t4a", 3'd1);
    drive(2'b01, 3'd3, 3'd0, 3'd4);
    lanes("t4b", 4'b0111, 4'b0000, {3'd0, 3'd3, 3'd2, 3'd1}, 4'b0100, 2'b01);
    tick("t4b", 3'd0);
    drive(2'b01, 3'd5, 3'd0, 3'd2);
    lanes("t5a", 4'b0011, 4'b0000, {3'd0, 3'd0, 3'd1, 3'd0}, 4'b0000, 2'b00);
    tick("t5a", 3'd2);
    drive(2'b01, 3'd5, 3'd0, 3'd0);
    lanes("t5b", 4'b0000, 4'b0000, 12'h000, 4'b0000, 2'b00);
    tick("t5b", 3'd2);
    drive(2'b01, 3'd5, 3'd0, 3'd4);
    lanes("t5c", 4'b1111, 4'b0000, {3'd5, 3'd4, 3'd3, 3'd2}, 4'b1000, 2'b01);
    tick("t5c", 3'd0);
    drive(2'b10, 3'd7, 3'd1, 3'd4);
    lanes("t6a", 4'b0000, 4'b0000, 12'h000, 4'b0000, 2'b00);
    tick("t6a", 3'd0);
    drive(2'b01, 3'd7, 3'd1, 3'd3);
    lanes("t6b", 4'b0111, 4'b0000, {3'd0, 3'd2, 3'd1, 3'd0}, 4'b0000, 2'b00);
    tick("t6b", 3'd3);
    drive(2'b10, 3'd7, 3'd1, 3'd4);
    lanes("t6c", 4'b0000, 4'b0000, 12'h000, 4'b0000, 2'b00);
    tick("t6c", 3'd3);
    drive(2'b01, 3'd7, 3'd1, 3'd3);
    lanes("t6d", 4'b0111, 4'b0000, {3'd0, 3'd5, 3'd4, 3'd3}, 4'b0000, 2'b00);
    rst_n = 1'b0;
    #1;
    chk("t6e.remain", 32'(uop_index_remain), 32'd0);
    lanes("t6e", 4'b0000, 4'b0000, 12'h000, 4'b0000, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    lanes("t6f", 4'b0111, 4'b0000, {3'd0, 3'd2, 3'd1, 3'd0}, 4'b0000, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
